acia_tx_queue: RTL and testbench
================================

ACIA_TX_QUEUE -- requirements
Module: acia_tx_queue

Interface
REQ-001 Parameter DEPTH, default 16, transmit queue depth in bytes; power of two, at least 2.
REQ-002 Parameter CTRL_WORD, default 8'h00, ACIA control byte written after the master reset.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_data  input  8  byte to queue.
REQ-006 wr_valid  input  1  producer offers wr_data.
REQ-007 wr_ready  output  1  queue can accept; a byte is transferred when wr_valid & wr_ready.
REQ-008 flush  input  1  synchronous discard of all queued bytes.
REQ-009 level  output  $clog2(DEPTH)+1  number of bytes held.
REQ-010 busy  output  1  queue not empty, or FSM not in IDLE.
REQ-011 acia_cs  output  1  ACIA chip select.
REQ-012 acia_we  output  1  ACIA write enable.
REQ-013 acia_rs  output  1  ACIA register select: 0 = control/status, 1 = data.
REQ-014 acia_din  output  8  byte driven to the ACIA data input.
REQ-015 acia_dout  input  8  ACIA registered read data, valid the cycle after a read strobe.

Function
REQ-016 FIFO SHALL be DEPTH x 8 circular buffer; read/write pointers wrap modulo DEPTH; level updated same edge as push/pop.
REQ-017 wr_ready SHALL equal (level != DEPTH) & ~flush, registered-state based; pop in same cycle does not raise wr_ready at full.
REQ-018 Simultaneous push and pop SHALL leave level unchanged and preserve byte order.
REQ-019 flush SHALL zero level and both pointers next edge; an in-flight SEND completes, remaining bytes discarded.
REQ-020 FSM states SHALL be CFG_RST, CFG_CTRL, IDLE, POLL, WAIT, SEND.
REQ-021 CFG_RST: one cycle cs=1 we=1 rs=0 din=8'h03 (ACIA master reset) -> CFG_CTRL.
REQ-022 CFG_CTRL: one cycle cs=1 we=1 rs=0 din=CTRL_WORD -> IDLE.
REQ-023 IDLE: strobes low; level != 0 -> POLL.
REQ-024 POLL: one cycle cs=1 we=0 rs=0 (status read) -> WAIT.
REQ-025 WAIT: strobes low; sample acia_dout[1] (TX empty): 1 -> SEND, 0 -> POLL.
REQ-026 SEND: one cycle cs=1 we=1 rs=1 din=FIFO head, pop head -> IDLE.
REQ-027 If flush empties queue while in POLL/WAIT, WAIT SHALL return to IDLE instead of SEND.
REQ-028 acia_cs/we/rs/din SHALL be registered outputs; acia_din = 8'h00 whenever acia_cs=0.
REQ-029 Latency: byte pushed at edge T into empty queue with ACIA idle SHALL produce SEND strobe in cycle T+4.
REQ-030 Exactly one SEND per queued byte; no data write while acia_dout[1] sampled 0 in the preceding WAIT.
REQ-031 Back-to-back bytes SHALL each require a fresh POLL/WAIT; status never reused across sends.

Reset
REQ-032 On rst: pointers=0, level=0, state=CFG_RST, acia_cs=acia_we=acia_rs=0, acia_din=8'h00, wr_ready=0 while rst high, busy=1.
REQ-033 rst assertion mid-SEND SHALL abort immediately; queued bytes lost; config sequence reruns after release.
REQ-034 wr_ready SHALL be 1 from the first cycle after rst release (FIFO accepts during config).

Structure
REQ-035 State encoding and ACIA constants (8'h03 master-reset, status bit index 1, rs values) SHALL live in shared package acia_pkg.
REQ-036 FIFO SHALL be a sub-module byte_fifo (DEPTH param, push/pop/flush, level, full, empty, head data); FSM in acia_tx_queue.

Verification
REQ-037 Reset release, no pushes -> cycle 1 write 8'h03 rs=0, cycle 2 write CTRL_WORD rs=0, then strobes idle indefinitely.
REQ-038 Push 8'h41 into empty queue, ACIA model txe=1 -> data write rs=1 din=8'h41 at T+4; level 1 -> 0.
REQ-039 Push 8'h55, model holds txe=0 for 20 cycles -> repeated POLL/WAIT pairs, no data write until txe=1, then exactly one write of 8'h55.
REQ-040 Push DEPTH+1 bytes 0..16 with txe=0 -> wr_ready drops at level 16, byte 16 not accepted; release txe -> bytes 0..15 sent in order.
REQ-041 Push 3 bytes, flush during first WAIT -> at most one data write (byte 0), level 0, FSM back to IDLE.
REQ-042 Assert rst during SEND -> strobes 0 same cycle asynchronously, level 0, config sequence repeats after release.

Source files
------------

// File: rtl/acia_pkg.sv
// Shared ACIA constants, FSM state encoding and bus-cycle helpers for the transmit queue.
package acia_pkg;

  typedef enum logic [2:0] {
    CFG_RST,
    CFG_CTRL,
    IDLE,
    POLL,
    WAIT,
    SEND
  } acia_state_t;

  localparam logic [7:0]  ACIA_MASTER_RESET = 8'h03;
  localparam int unsigned ACIA_TXE_BIT      = 1;
  localparam logic        ACIA_RS_CTRL      = 1'b0;
  localparam logic        ACIA_RS_DATA      = 1'b1;

  typedef struct packed {
    logic       cs;
    logic       we;
    logic       rs;
    logic [7:0] din;
  } acia_bus_t;

  function automatic acia_bus_t acia_write(input logic rs, input logic [7:0] data);
    acia_bus_t b;
    b.cs  = 1'b1;
    b.we  = 1'b1;
    b.rs  = rs;
    b.din = data;
    return b;
  endfunction

  function automatic acia_bus_t acia_status_read();
    acia_bus_t b;
    b.cs  = 1'b1;
    b.we  = 1'b0;
    b.rs  = ACIA_RS_CTRL;
    b.din = 8'h00;
    return b;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 circular byte buffer with synchronous flush; level tracks occupancy on the push/pop edge.
module byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wr_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [7:0]               head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign push_ok = push & ~full & ~flush;
  assign pop_ok  = pop & ~empty;

  // DEPTH is a power of two, so pointer increments wrap modulo DEPTH naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/acia_tx_queue.sv
// Byte transmit queue feeding a 6850-style ACIA: configures it after reset, then polls TX-empty before each data write.
module acia_tx_queue
  import acia_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  CTRL_WORD = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     busy,
  output logic                     acia_cs,
  output logic                     acia_we,
  output logic                     acia_rs,
  output logic [7:0]               acia_din,
  input  logic [7:0]               acia_dout
);

  acia_state_t state_q, state_d;
  acia_bus_t   bus_q, bus_d;
  logic        run_q, run_d;
  logic        push, pop, full, empty;
  logic [7:0]  head;
  logic        unused_dout;

  assign unused_dout = ^{acia_dout[7:ACIA_TXE_BIT+1], acia_dout[ACIA_TXE_BIT-1:0]};

  assign wr_ready = run_q & ~full & ~flush;
  assign push     = wr_valid & wr_ready;
  assign busy     = ~empty | (state_q != IDLE);

  assign acia_cs  = bus_q.cs;
  assign acia_we  = bus_q.we;
  assign acia_rs  = bus_q.rs;
  assign acia_din = bus_q.din;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_data (wr_data),
    .pop     (pop),
    .flush   (flush),
    .head    (head),
    .level   (level),
    .full    (full),
    .empty   (empty)
  );

  // Bus strobes are registered from the next state so each strobe lines up with its state;
  // run_q holds CFG_RST for the release cycle so the master-reset write is still emitted.
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    bus_d   = '0;
    case (state_q)
      CFG_RST:  if (run_q) state_d = CFG_CTRL;
      CFG_CTRL: state_d = IDLE;
      IDLE:     if (!empty) state_d = POLL;
      POLL:     state_d = WAIT;
      WAIT: begin
        if (empty)                          state_d = IDLE;
        else if (acia_dout[ACIA_TXE_BIT])   state_d = SEND;
        else                                state_d = POLL;
      end
      SEND:     state_d = IDLE;
      default:  state_d = CFG_RST;
    endcase

    pop = (state_q == WAIT) && (state_d == SEND);

    case (state_d)
      CFG_RST:  bus_d = acia_write(ACIA_RS_CTRL, ACIA_MASTER_RESET);
      CFG_CTRL: bus_d = acia_write(ACIA_RS_CTRL, CTRL_WORD);
      POLL:     bus_d = acia_status_read();
      SEND:     bus_d = acia_write(ACIA_RS_DATA, head);
      default:  bus_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CFG_RST;
      run_q   <= 1'b0;
      bus_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      bus_q   <= bus_d;
    end
  end

endmodule

// File: tb/tb_acia_tx_queue.sv
// Randomized and directed bench for acia_tx_queue against a queue-based model and an ACIA status model.
module tb_acia_tx_queue;

  localparam int unsigned DEPTH = 16;
  localparam logic [7:0]  CTRL  = 8'h15;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [7:0]             wr_data = '0;
  logic                   wr_valid = 1'b0;
  logic                   wr_ready;
  logic                   flush = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic                   busy;
  logic                   acia_cs, acia_we, acia_rs;
  logic [7:0]             acia_din;
  logic [7:0]             acia_dout = '0;

  logic        txe = 1'b1;
  logic        last_txe = 1'b0;
  int unsigned poll_cnt = 0;

  logic [7:0]  mq[$];
  int unsigned n_chk = 0, n_fail = 0;
  int unsigned cyc = 0, send_cnt = 0, last_send_cyc = 0, poll_at_send = 0;
  logic        prev_acc = 1'b0, prev_f = 1'b0;
  logic [7:0]  prev_d = '0;

  acia_tx_queue #(.DEPTH(DEPTH), .CTRL_WORD(CTRL)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_data   (wr_data),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .flush     (flush),
    .level     (level),
    .busy      (busy),
    .acia_cs   (acia_cs),
    .acia_we   (acia_we),
    .acia_rs   (acia_rs),
    .acia_din  (acia_din),
    .acia_dout (acia_dout)
  );

  always #5 clk = ~clk;

  // ACIA: status valid only the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    logic [7:0] rnd;
    rnd = 8'($urandom);
    if (acia_cs && !acia_we && !acia_rs) begin
      acia_dout <= {rnd[7:2], txe, rnd[0]};
      last_txe  <= txe;
      poll_cnt  <= poll_cnt + 1;
    end else begin
      acia_dout <= rnd;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic f);
    logic exp_ready;
    @(negedge clk);
    cyc++;
    if (acia_cs && acia_we && acia_rs) begin
      send_cnt++;
      last_send_cyc = cyc;
      check("send_fresh_poll", 32'(poll_cnt > poll_at_send), 32'd1);
      check("send_txe", 32'(last_txe), 32'd1);
      poll_at_send = poll_cnt;
      check("send_expected", 32'(mq.size() != 0), 32'd1);
      if (mq.size() != 0) check("send_data", 32'(acia_din), 32'(mq.pop_front()));
    end
    if (!acia_cs) check("din_idle", 32'(acia_din), 32'd0);
    if (prev_f) mq.delete();
    else if (prev_acc) mq.push_back(prev_d);
    check("level", 32'(level), 32'(mq.size()));
    if (mq.size() != 0) check("busy_nonempty", 32'(busy), 32'd1);
    wr_valid = v;
    wr_data  = d;
    flush    = f;
    #1;
    exp_ready = (mq.size() != DEPTH) && !f;
    check("wr_ready", 32'(wr_ready), 32'(exp_ready));
    prev_acc = v && exp_ready;
    prev_d   = d;
    prev_f   = f;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    flush    = 1'b0;
    #1;
    check("rst_strobes", 32'({acia_cs, acia_we, acia_rs}), 32'd0);
    check("rst_din", 32'(acia_din), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    mq.delete();
    prev_acc = 1'b0;
    prev_f   = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    check("cfg_master_reset", 32'({acia_cs, acia_we, acia_rs, acia_din}), 32'({3'b110, 8'h03}));
    step(1'b0, 8'h00, 1'b0);
    check("cfg_ctrl_word", 32'({acia_cs, acia_we, acia_rs, acia_din}), 32'({3'b110, CTRL}));
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check("post_cfg_idle", 32'({acia_cs, acia_we, acia_rs}), 32'd0);
    end
    check("post_cfg_busy", 32'(busy), 32'd0);
  endtask

  task automatic drain(input string tag, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      if (mq.size() == 0 && !busy && !prev_acc) break;
      step(1'b0, 8'h00, 1'b0);
    end
    check(tag, 32'({mq.size() == 0, busy}), 32'({1'b1, 1'b0}));
  endtask

  initial begin
    int unsigned s0, p0, pc;

    do_reset();

    // Single byte latency with the transmitter ready
    txe = 1'b1;
    s0  = send_cnt;
    step(1'b1, 8'h41, 1'b0);
    pc = cyc;
    repeat (6) step(1'b0, 8'h00, 1'b0);
    check("latency", last_send_cyc - pc, 32'd4);
    check("single_send", send_cnt - s0, 32'd1);

    // Transmitter busy for 20 cycles: repeated polls, no write
    txe = 1'b0;
    s0  = send_cnt;
    p0  = poll_cnt;
    step(1'b1, 8'h55, 1'b0);
    repeat (20) step(1'b0, 8'h00, 1'b0);
    check("no_send_while_txe0", send_cnt - s0, 32'd0);
    check("repeated_polls", 32'(poll_cnt - p0 >= 5), 32'd1);
    txe = 1'b1;
    repeat (8) step(1'b0, 8'h00, 1'b0);
    check("send_after_txe", send_cnt - s0, 32'd1);

    // Overfill by one byte with the transmitter stalled
    txe = 1'b0;
    s0  = send_cnt;
    for (int i = 0; i <= 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check("full_level", 32'(level), DEPTH);
    check("full_ready", 32'(wr_ready), 32'd0);
    txe = 1'b1;
    drain("drain_full", 200);
    check("full_send_count", send_cnt - s0, 32'd16);

    // Flush during the first WAIT
    txe = 1'b1;
    s0  = send_cnt;
    step(1'b1, 8'hA0, 1'b0);
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hA2, 1'b0);
    check("poll_before_flush", 32'({acia_cs, acia_we}), 32'({1'b1, 1'b0}));
    step(1'b0, 8'h00, 1'b1);
    repeat (8) step(1'b0, 8'h00, 1'b0);
    check("flush_at_most_one", 32'(send_cnt - s0 <= 1), 32'd1);
    check("flush_level", 32'(level), 32'd0);
    check("flush_idle", 32'(busy), 32'd0);

    // Random traffic, flushes and transmitter stalls
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) txe = ~txe;
      step(1'(($urandom_range(0, 2) != 0)), 8'($urandom), 1'(($urandom_range(0, 59) == 0)));
    end
    txe = 1'b1;
    drain("drain_random", 200);

    // Reset asserted while a data write is on the bus
    txe = 1'b1;
    s0  = send_cnt;
    step(1'b1, 8'h77, 1'b0);
    step(1'b1, 8'h78, 1'b0);
    step(1'b1, 8'h79, 1'b0);
    for (int i = 0; i < 20; i++) begin
      if (send_cnt != s0) break;
      step(1'b0, 8'h00, 1'b0);
    end
    check("send_seen_before_rst", 32'(send_cnt != s0), 32'd1);
    check("pre_rst_send", 32'(acia_cs & acia_rs), 32'd1);
    do_reset();
    s0 = send_cnt;
    step(1'b1, 8'h5A, 1'b0);
    drain("drain_after_rst", 40);
    check("send_after_rst", send_cnt - s0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
